// File: rtl/clock_pkg.sv
// Shared widths, limits and alarm state encoding for the time-of-day keeper.
package clock_pkg;

  localparam int HH_W        = 5;
  localparam int MM_W        = 6;
  localparam int SS_W        = 6;
  localparam int CNT_W       = 10;
  localparam int MAX_MIN_SEC = 59;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } alm_state_t;

endpackage

// File: rtl/wrap_counter.sv
// Modulo-(MAX+1) counter with synchronous load; wrap is the combinational carry-out
// so the next digit can be chained directly off it.
module wrap_counter #(
  parameter int MAX   = 59,
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  assign wrap = en && !load && (q == MAX_V);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (en) begin
      q <= wrap ? '0 : q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/time_of_day_keeper.sv
// Binary hh:mm:ss keeper driven by the seconds tick, with one alarm and its
// ring / snooze / auto-off sequencer.
//
//   state  | meaning
//   IDLE   | alarm quiet, waiting for the time to reach the alarm minute
//   RING   | buzzer on; ack, disarm, snooze or RING_SEC ticks leave
//   SNOOZE | buzzer off; re-rings after SNOOZE_SEC ticks unless ack/disarm
module time_of_day_keeper
  import clock_pkg::*;
#(
  parameter int HOUR_MAX   = 23,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tick,
  input  logic            run,
  input  logic            set_en,
  input  logic [HH_W-1:0] set_hh,
  input  logic [MM_W-1:0] set_mm,
  input  logic [SS_W-1:0] set_ss,
  input  logic            alm_wr,
  input  logic [HH_W-1:0] alm_hh,
  input  logic [MM_W-1:0] alm_mm,
  input  logic            alm_arm,
  input  logic            ack,
  input  logic            snooze,
  output logic [HH_W-1:0] hh,
  output logic [MM_W-1:0] mm,
  output logic [SS_W-1:0] ss,
  output logic            min_pulse,
  output logic            day_pulse,
  output logic            ringing,
  output logic            snoozing,
  output logic            set_err
);

  localparam logic [HH_W-1:0]  HOUR_LAST   = HH_W'(HOUR_MAX);
  localparam logic [MM_W-1:0]  MIN_LAST    = MM_W'(MAX_MIN_SEC);
  localparam logic [SS_W-1:0]  SEC_LAST    = SS_W'(MAX_MIN_SEC);
  localparam logic [CNT_W-1:0] RING_LAST   = CNT_W'(RING_SEC - 1);
  localparam logic [CNT_W-1:0] SNOOZE_LAST = CNT_W'(SNOOZE_SEC - 1);

  logic            adv, sec_tick, set_ok, alm_ok, load_time;
  logic            ss_wrap, mm_wrap, hh_wrap, trigger;
  logic [MM_W-1:0] mm_new;
  logic [HH_W-1:0] hh_new;
  logic [HH_W-1:0] alarm_hh;
  logic [MM_W-1:0] alarm_mm;
  alm_state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  // A load always wins over a tick in the same cycle, even when the load is rejected.
  assign adv       = tick & run & ~set_en;
  assign sec_tick  = tick & run;
  assign set_ok    = (set_hh <= HOUR_LAST) && (set_mm <= MIN_LAST) && (set_ss <= SEC_LAST);
  assign alm_ok    = (alm_hh <= HOUR_LAST) && (alm_mm <= MIN_LAST);
  assign load_time = set_en & set_ok;

  wrap_counter #(.MAX(MAX_MIN_SEC), .WIDTH(SS_W)) u_ss (
    .clk  (clk),
    .rst  (rst),
    .en   (adv),
    .load (load_time),
    .d    (set_ss),
    .q    (ss),
    .wrap (ss_wrap)
  );

  wrap_counter #(.MAX(MAX_MIN_SEC), .WIDTH(MM_W)) u_mm (
    .clk  (clk),
    .rst  (rst),
    .en   (ss_wrap),
    .load (load_time),
    .d    (set_mm),
    .q    (mm),
    .wrap (mm_wrap)
  );

  wrap_counter #(.MAX(HOUR_MAX), .WIDTH(HH_W)) u_hh (
    .clk  (clk),
    .rst  (rst),
    .en   (mm_wrap),
    .load (load_time),
    .d    (set_hh),
    .q    (hh),
    .wrap (hh_wrap)
  );

  // Time after this tick lands on alarm_hh:alarm_mm:00 only when seconds wrap.
  assign mm_new  = mm_wrap ? '0 : (ss_wrap ? mm + MM_W'(1) : mm);
  assign hh_new  = hh_wrap ? '0 : (mm_wrap ? hh + HH_W'(1) : hh);
  assign trigger = ss_wrap & alm_arm & (mm_new == alarm_mm) & (hh_new == alarm_hh);

  always_ff @(posedge clk) begin
    if (rst) begin
      min_pulse <= 1'b0;
      day_pulse <= 1'b0;
      set_err   <= 1'b0;
      alarm_hh  <= '0;
      alarm_mm  <= '0;
    end else begin
      min_pulse <= ss_wrap;
      day_pulse <= hh_wrap;
      set_err   <= (set_en & ~set_ok) | (alm_wr & ~alm_ok);
      if (alm_wr & alm_ok) begin
        alarm_hh <= alm_hh;
        alarm_mm <= alm_mm;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (trigger) begin
          state_nxt = RING;
          cnt_nxt   = '0;
        end
      end
      RING: begin
        if (ack || !alm_arm) begin
          state_nxt = IDLE;
        end else if (snooze) begin
          state_nxt = SNOOZE;
          cnt_nxt   = '0;
        end else if (sec_tick) begin
          if (cnt == RING_LAST) state_nxt = IDLE;
          else                  cnt_nxt   = cnt + CNT_W'(1);
        end
      end
      SNOOZE: begin
        if (ack || !alm_arm) begin
          state_nxt = IDLE;
        end else if (sec_tick) begin
          if (cnt == SNOOZE_LAST) begin
            state_nxt = RING;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ringing  = (state == RING);
    snoozing = (state == SNOOZE);
  end

endmodule
